// File: rtl/soundrive_fifo.sv
// Soundrive/Covox-style multichannel 8-bit DAC port. CPU port writes feed per-channel
// FIFOs drained by a ce-driven playback divider; mode 0 latches writes straight to the DACs.
module soundrive_fifo #(
  parameter int unsigned              CHANNELS    = 4,
  parameter int unsigned              DEPTH       = 16,
  parameter logic [CHANNELS*8-1:0]    PORTS       = {8'h5F, 8'h4F, 8'h1F, 8'h0F},
  parameter logic [7:0]               STATUS_PORT = 8'hBF,
  parameter logic [15:0]              DIV         = 16'd80
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  iorq,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [7:0]            a,
  input  logic [7:0]            d,
  output logic [7:0]            q,
  output logic                  qe,
  output logic [CHANNELS*8-1:0] out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic        wsel, rsel;
  logic        wsel_q, rsel_q;
  logic        wr_evt, rd_evt;
  logic        status_wr, flush;
  logic        mode;
  logic        clr_pending, clr;
  logic [15:0] div_cnt;
  logic        tick;

  logic [CHANNELS-1:0] full_v;
  logic [CHANNELS-1:0] und_v;
  logic [3:0]          full4, und4;

  assign wsel = !iorq && !wr;
  assign rsel = !iorq && !rd;

  // Strobe history only advances on ce, so a long bus cycle yields exactly one event.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
    end else if (ce) begin
      wsel_q <= wsel;
      rsel_q <= rsel;
    end
  end

  assign wr_evt    = ce && wsel && !wsel_q;
  assign rd_evt    = ce && rsel && !rsel_q && (a == STATUS_PORT);
  assign status_wr = wr_evt && (a == STATUS_PORT);
  assign flush     = status_wr && (d[0] != mode);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode        <= 1'b0;
      clr_pending <= 1'b0;
      div_cnt     <= '0;
    end else if (ce) begin
      clr_pending <= rd_evt;
      if (status_wr) mode <= d[0];
      if (!mode || div_cnt == DIV - 16'd1) div_cnt <= '0;
      else                                 div_cnt <= div_cnt + 16'd1;
    end
  end

  assign tick = ce && mode && !flush && (div_cnt == DIV - 16'd1);
  assign clr  = ce && clr_pending;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [7:0]    sample;
    logic          und;
    logic          hit, push, pop;

    assign hit  = wr_evt && (a == PORTS[8*i +: 8]);
    assign push = hit && mode && (cnt < CW'(DEPTH));
    assign pop  = tick && (cnt != '0);

    // NOTE: sample storage carries no reset; empty/full is tracked by the pointers and
    // count, so stale bytes are never observable.
    always_ff @(posedge clock) begin
      if (push) mem[wp] <= d;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else if (flush) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)            sample <= '0;
      else if (hit && !mode) sample <= d;
      else if (pop)          sample <= mem[rp];
    end

    // A tick on an empty FIFO outranks a pending read-clear so no underrun is lost.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      und <= 1'b0;
      else if (flush)                  und <= 1'b0;
      else if (tick && cnt == '0)      und <= 1'b1;
      else if (clr)                    und <= 1'b0;
    end

    assign out[8*i +: 8] = sample;
    assign full_v[i]     = (cnt == CW'(DEPTH));
    assign und_v[i]      = und;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    full4                 = '0;
    und4                  = '0;
    full4[CHANNELS-1:0]   = full_v;
    und4[CHANNELS-1:0]    = und_v;
  end

  assign q  = {und4, full4};
  assign qe = rsel && (a == STATUS_PORT);

endmodule

// File: tb/tb_soundrive_fifo.sv
// Scoreboard bench for soundrive_fifo: stimulus queues expected DAC changes and status
// reads; monitors compare whenever out changes or qe rises.
module tb_soundrive_fifo;

  localparam logic [7:0]  STATUS = 8'hBF;
  localparam logic [15:0] DIV_A  = 16'd4;
  localparam logic [15:0] DIV_B  = 16'd100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, iorq, wr, rd;
  logic [7:0]  a, d;
  logic        sel_b;
  logic        iorq_a, iorq_b;
  logic [7:0]  q_a, q_b;
  logic        qe_a, qe_b;
  logic [31:0] out_a, out_b;

  assign iorq_a = sel_b ? 1'b1 : iorq;
  assign iorq_b = sel_b ? iorq : 1'b1;

  soundrive_fifo #(.DIV(DIV_A)) dut_a (
    .clock(clk), .reset(rst_n), .ce(ce), .iorq(iorq_a), .wr(wr), .rd(rd),
    .a(a), .d(d), .q(q_a), .qe(qe_a), .out(out_a)
  );

  soundrive_fifo #(.DIV(DIV_B)) dut_b (
    .clock(clk), .reset(rst_n), .ce(ce), .iorq(iorq_b), .wr(wr), .rd(rd),
    .a(a), .d(d), .q(q_b), .qe(qe_b), .out(out_b)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } out_exp_t;

  out_exp_t    out_q_a[$], out_q_b[$];
  logic [7:0]  stat_q_a[$], stat_q_b[$];
  logic [31:0] last_a = '0, last_b = '0;
  int          n_checks = 0, n_err = 0;
  int          last_ev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  logic [31:0] prev_a = '0, prev_b = '0;
  logic        qe_prev_a = 1'b0, qe_prev_b = 1'b0;

  always @(negedge clk) begin : mon_a
    out_exp_t e;
    if (out_a !== prev_a) begin
      if (out_q_a.size() == 0) check("out_a unexpected change", out_a, prev_a);
      else begin
        e = out_q_a.pop_front();
        check("out_a value", out_a, e.val);
        check("out_a cycle", 32'(cyc_n), 32'(e.cyc));
      end
      prev_a = out_a;
    end
    if (qe_a && !qe_prev_a) begin
      if (stat_q_a.size() == 0) check("qe_a unexpected", 32'(qe_a), 32'd0);
      else                      check("q_a status", 32'(q_a), 32'(stat_q_a.pop_front()));
    end
    qe_prev_a = qe_a;
  end

  always @(negedge clk) begin : mon_b
    out_exp_t e;
    if (out_b !== prev_b) begin
      if (out_q_b.size() == 0) check("out_b unexpected change", out_b, prev_b);
      else begin
        e = out_q_b.pop_front();
        check("out_b value", out_b, e.val);
        check("out_b cycle", 32'(cyc_n), 32'(e.cyc));
      end
      prev_b = out_b;
    end
    if (qe_b && !qe_prev_b) begin
      if (stat_q_b.size() == 0) check("qe_b unexpected", 32'(qe_b), 32'd0);
      else                      check("q_b status", 32'(q_b), 32'(stat_q_b.pop_front()));
    end
    qe_prev_b = qe_b;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc_n < c) cyc();
  endtask

  task automatic push_out(input bit on_b, input logic [31:0] val, input int at);
    out_exp_t e;
    e.val = val;
    e.cyc = at;
    if (on_b) begin out_q_b.push_back(e); last_b = val; end
    else      begin out_q_a.push_back(e); last_a = val; end
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] val,
                          input bit expect_chg = 1'b0, input logic [31:0] exp_out = '0);
    a = port; d = val; iorq = 1'b0; wr = 1'b0;
    cyc();
    last_ev = cyc_n;
    if (expect_chg) push_out(sel_b, exp_out, cyc_n);
    iorq = 1'b1; wr = 1'b1;
    cyc();
  endtask

  task automatic status_read(input logic [7:0] exp);
    if (sel_b) stat_q_b.push_back(exp);
    else       stat_q_a.push_back(exp);
    a = STATUS; iorq = 1'b0; rd = 1'b0;
    cyc();
    iorq = 1'b1; rd = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    if (last_a != '0) push_out(1'b0, '0, cyc_n);
    if (last_b != '0) push_out(1'b1, '0, cyc_n);
    rst_n = 1'b0;
    cyc();
    cyc();
    check("reset out_a", out_a, 32'h0);
    check("reset q_a", 32'(q_a), 32'h0);
    check("reset out_b", out_b, 32'h0);
    check("reset q_b", 32'(q_b), 32'h0);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d exceeded limit", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n = 1'b0; ce = 1'b1; iorq = 1'b1; wr = 1'b1; rd = 1'b1;
    a = '0; d = '0; sel_b = 1'b0;

    // Legacy mode: direct latch, ce gating, unmapped port ignored.
    do_reset();
    status_read(8'h00);
    sel_b = 1'b1;
    status_read(8'h00);
    sel_b = 1'b0;
    ce = 1'b0;
    io_write(8'h0F, 8'h99);
    status_read(8'h00);
    ce = 1'b1;
    io_write(8'h0F, 8'h80, 1'b1, 32'h0000_0080);
    io_write(8'h33, 8'h44);
    io_write(8'h5F, 8'h22, 1'b1, 32'h2200_0080);

    // Buffered, DIV=4: ticks at e0+4k; 0x22 push coincides with the tick popping 0x11.
    do_reset();
    io_write(STATUS, 8'h01);
    e0 = last_ev;
    push_out(1'b0, 32'h0000_1100, e0 + 4);
    push_out(1'b0, 32'h0000_2200, e0 + 8);
    push_out(1'b0, 32'h0000_3300, e0 + 12);
    io_write(8'h1F, 8'h11);
    io_write(8'h1F, 8'h22);
    io_write(8'h1F, 8'h33);
    wait_until(e0 + 12);
    status_read(8'hD0);
    wait_until(e0 + 16);
    status_read(8'hF0);
    status_read(8'h00);

    // Overflow on DUT B (DIV=100): 17 writes, 17th dropped, 16 ticks drain in order.
    do_reset();
    sel_b = 1'b1;
    io_write(STATUS, 8'h01);
    e0 = last_ev;
    for (int j = 1; j <= 16; j++) push_out(1'b1, 32'(j) << 16, e0 + 100 * j);
    for (int j = 1; j <= 17; j++) io_write(8'h4F, 8'(j));
    status_read(8'h04);
    wait_until(e0 + 1650);
    status_read(8'hB0);
    wait_until(e0 + 1700);
    status_read(8'hF0);

    // Strobe held for 10 ce cycles pushes once.
    do_reset();
    io_write(STATUS, 8'h01);
    e0 = last_ev;
    push_out(1'b1, 32'h0000_00A5, e0 + 100);
    push_out(1'b1, 32'h0000_005A, e0 + 200);
    a = 8'h0F; d = 8'hA5; iorq = 1'b0; wr = 1'b0;
    repeat (10) cyc();
    iorq = 1'b1; wr = 1'b1;
    cyc();
    io_write(8'h0F, 8'h5A);
    wait_until(e0 + 250);
    status_read(8'hE0);
    wait_until(e0 + 300);
    status_read(8'hF0);

    // Reset with five queued samples: queue discarded, mode back to legacy.
    do_reset();
    io_write(STATUS, 8'h01);
    for (int j = 0; j < 5; j++) io_write(8'h5F, 8'h31 + 8'(j));
    status_read(8'h00);
    rst_n = 1'b0;
    cyc();
    check("mid-burst reset out_b", out_b, 32'h0);
    check("mid-burst reset q_b", 32'(q_b), 32'h0);
    rst_n = 1'b1;
    cyc();
    io_write(8'h5F, 8'h77, 1'b1, 32'h7700_0000);
    io_write(STATUS, 8'h01);
    e0 = last_ev;
    wait_until(e0 + 100);
    status_read(8'hF0);

    repeat (3) cyc();
    check("out_q_a drained", 32'(out_q_a.size()), 32'd0);
    check("out_q_b drained", 32'(out_q_b.size()), 32'd0);
    check("stat_q_a drained", 32'(stat_q_a.size()), 32'd0);
    check("stat_q_b drained", 32'(stat_q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/soundrive_fifo.md
Name: soundrive_fifo

Overview:
- Next-generation Soundrive/Covox-style multichannel 8-bit DAC port block.
- CPU I/O writes to per-channel ports are pushed into per-channel FIFOs.
- A ce-driven rate divider pops one sample per channel per playback tick, so sample playback is decoupled from CPU write timing.
- A legacy mode bypasses the FIFOs and latches port writes directly, matching classic Soundrive behaviour. Sits between the Z80 I/O bus decode and the audio mixer.

Parameters:
- CHANNELS, 4, number of DAC channels; legal range 1..4.
- DEPTH, 16, FIFO entries per channel; power of two, 2..256.
- PORTS, {8'h5F,8'h4F,8'h1F,8'h0F}, packed CHANNELS×8 low-address ports; channel i uses bits [8i+7:8i].
- STATUS_PORT, 8'hBF, low address of the status/control port.
- DIV, 16'd80, ce ticks per playback tick; legal range ≥1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state advances only when ce=1
- iorq  in  1  active-low I/O request
- wr  in  1  active-low write strobe
- rd  in  1  active-low read strobe
- a  in  8  low address byte
- d  in  8  CPU write data
- q  out  8  status read data
- qe  out  1  high while a status read is decoded (drives the bus mux)
- out  out  CHANNELS×8  current DAC sample per channel; channel i uses bits [8i+7:8i]

Behaviour:
- Reset (async, reset=0):
  - out=0, q=0, FIFOs empty (pointers and counts 0).
  - Divider=0, mode=0 (legacy), underrun flags cleared.
  - Reset asserted mid-burst discards all queued samples.
- Write detection:
  - wsel = !iorq && !wr.
  - A write event is the first ce cycle in which wsel=1 and a matches, with wsel=0 on the previous ce cycle (edge detect registered on ce).
  - Exactly one push per bus cycle, however many ce cycles the strobe lasts.
- Status/control port:
  - Write event to STATUS_PORT: mode=d[0]. A mode change flushes all FIFOs and clears the underrun flags.
  - qe = !iorq && !rd && a==STATUS_PORT (combinational).
  - q = {underrun[3:0], full[3:0]}; unused channel bits read 0.
  - A read event (rd edge, same rule as writes) clears the sticky underrun flags on the following ce cycle.
- Mode 0 (legacy):
  - A write event to channel i port loads out[i] with d on that ce cycle; 1-ce latency from the event.
  - FIFOs and the divider stay idle; the divider is held at 0.
- Mode 1 (buffered):
  - A write event to channel i pushes d if count_i<DEPTH.
  - If the FIFO is full the write is dropped; contents are unchanged and out is unaffected.
  - Divider counts ce cycles 0..DIV-1. The tick is the ce cycle where the divider=DIV-1, and the divider wraps to 0.
  - On a tick, each channel with count>0 pops its head into out[i] (out updates on that same ce edge).
  - On a tick, a channel with count==0 holds out[i] and sets underrun[i] (sticky).
- Simultaneous push and pop on the same channel in the same ce cycle: both happen; count is unchanged; a pop from an empty FIFO with a simultaneous push is treated as underrun (the pushed byte stays queued).
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- full[i] = (count_i==DEPTH).
- With ce=0 nothing changes except async reset; qe and q remain combinational.

Test Plan:
- Reset, mode 0; OUT (0x0F),0x80 then OUT (0x5F),0x22 → out[7:0]=0x80, out[31:24]=0x22 one ce after each event; others 0.
- Mode 1, DIV=4; push 0x11,0x22,0x33 to 0x1F → out[15:8] steps 0x11,0x22,0x33 on successive ticks (every 4 ce). The next tick holds 0x33, and a status read gives bit5=1; a second read gives bit5=0.
- Mode 1, DEPTH=16; 17 writes to 0x4F with ticks blocked (DIV large) → status bit2=1. The 17th byte is dropped; 16 ticks later the last output is the 16th byte.
- Write strobe held for 10 ce cycles → exactly one push (count=1).
- Push and tick on the same ce edge with count=1 → count stays 1; the popped and pushed bytes appear in order.
- Assert reset with 5 queued samples → out=0, all status 0. After release in mode 0, FIFOs are empty and mode=0.
